led_adc_sequencer: RTL and testbench
====================================

// Module: led_adc_sequencer
// PURPOSE
//  Time-multiplexes finger-clip LED between RED and IR at 100 Hz (5 ms per phase, 10 ms period).
//  Each phase: LED settle, one ADC conversion handshake, then routes the 8-bit sample to the RED or IR FIR.
//  Issues a one-cycle valid strobe per channel per period; the strobe is the FIR shift/clock enable.
//  Sits between the ADC interface and the RED/IR FIR filter instances.
// PARAMETERS
//  PHASE_CYCLES   250000  clock cycles per LED phase (5 ms @ 50 MHz); requires PHASE_CYCLES >= SETTLE_CYCLES+3
//  SETTLE_CYCLES  25000   cycles after LED turn-on before ADC_Start (0.5 ms)
//  CNT_W          18      phase counter width; must satisfy 2**CNT_W > PHASE_CYCLES
// PORTS
//  CLK              in   1  system clock, rising edge
//  rst_n            in   1  asynchronous active-low reset
//  enable           in   1  run sequencer; low forces IDLE
//  ADC_Data         in   8  conversion result, valid while ADC_Done=1
//  ADC_Done         in   1  one-cycle conversion-complete pulse from ADC
//  ADC_Start        out  1  one-cycle conversion request
//  LED_RED          out  1  red LED drive
//  LED_IR           out  1  infrared LED drive
//  RED_ADC_Value    out  8  last red sample, held between strobes
//  IR_ADC_Value     out  8  last IR sample, held between strobes
//  RED_Valid        out  1  one-cycle strobe: RED_ADC_Value updated
//  IR_Valid         out  1  one-cycle strobe: IR_ADC_Value updated
//  ADC_Timeout_Err  out  1  sticky: a phase ended with no ADC_Done
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, cnt 0. Async assert, sync release; mid-phase reset aborts instantly.
//  All outputs registered. States: IDLE, SETTLE, CONV, HOLD; 1-bit ch (0=RED,1=IR) selects LED/dest.
//  IDLE: LEDs 0. enable=1 -> next cycle SETTLE, ch=RED, cnt=0, LED_RED=1.
//  cnt increments every cycle in SETTLE/CONV/HOLD; phase ends when cnt==PHASE_CYCLES-1.
//  SETTLE: at cnt==SETTLE_CYCLES-1 -> CONV; ADC_Start=1 for exactly the first CONV cycle (cnt==SETTLE_CYCLES).
//  CONV: ADC_Done ignored in the ADC_Start cycle; later ADC_Done=1 at cycle t -> capture ADC_Data into
//   channel register, matching *_Valid=1 at t+1 only, state HOLD.
//  HOLD: wait for phase end. ADC_Done outside CONV ignored (no capture, no strobe).
//  Phase end (any of SETTLE/CONV/HOLD): cnt=0, ch toggles, SETTLE; LED outputs swap on the same edge
//   (exactly one LED on while enabled; never both on).
//  Timeout: phase end reached in CONV -> ADC_Timeout_Err=1 (sticky until rst_n), no strobe, value held,
//   next phase proceeds normally. ADC_Done coinciding with phase end in CONV: sample accepted, no error.
//  enable=0 in any state -> next cycle IDLE, LEDs 0, ADC_Start 0; in-flight conversion discarded.
//   Re-enable always restarts with RED phase, cnt=0. Held sample values and error flag unchanged.
//  Throughput: exactly one RED_Valid and one IR_Valid per 2*PHASE_CYCLES when ADC responds.
//  *_Valid never both high; never high in same cycle as ADC_Start.
// TESTING (PHASE_CYCLES=20, SETTLE_CYCLES=4)
//  Reset, enable=1 at c0 -> LED_RED=1 c1..c20; ADC_Start=1 at c5 only; ADC_Done+0xA5 at c8 -> RED_ADC_Value=0xA5, RED_Valid=1 c9 only.
//  Continuous run, ADC answers 3 cycles after start -> LED_RED/LED_IR alternate every 20 cycles, 1 RED_Valid + 1 IR_Valid per 40 cycles, IR sample 0x3C lands in IR_ADC_Value only.
//  IR phase with no ADC_Done -> ADC_Timeout_Err=1 at IR phase end, no IR_Valid, IR_ADC_Value unchanged, next RED phase samples normally.
//  ADC_Done pulses during SETTLE and HOLD with 0xFF -> no strobe, values unchanged.
//  enable=0 one cycle after ADC_Start -> next cycle both LEDs 0; later ADC_Done ignored; re-enable -> RED phase restarts, cnt=0.
//  rst_n low mid-HOLD -> all outputs 0 immediately (before next CLK edge); release -> IDLE.

Source files
------------

// File: rtl/led_adc_sequencer_if.sv
// ADC conversion handshake between the LED/ADC sequencer (master) and the ADC front end (slave).
interface led_adc_sequencer_if;
  logic       ADC_Start;
  logic [7:0] ADC_Data;
  logic       ADC_Done;

  modport master (output ADC_Start, input ADC_Data, input ADC_Done);
  modport slave  (input ADC_Start, output ADC_Data, output ADC_Done);
endinterface

// File: rtl/led_adc_sequencer.sv
// RED/IR LED time-multiplexer: per phase settle, one ADC conversion, route sample to the matching FIR
// with a one-cycle valid strobe. Sticky error when a phase closes without a conversion result.
module led_adc_sequencer #(
  parameter int PHASE_CYCLES  = 250000,
  parameter int SETTLE_CYCLES = 25000,
  parameter int CNT_W         = 18
) (
  input  logic                 CLK,
  input  logic                 rst_n,
  input  logic                 enable,
  led_adc_sequencer_if.master  adc,
  output logic                 LED_RED,
  output logic                 LED_IR,
  output logic [7:0]           RED_ADC_Value,
  output logic [7:0]           IR_ADC_Value,
  output logic                 RED_Valid,
  output logic                 IR_Valid,
  output logic                 ADC_Timeout_Err
);

  typedef enum logic [1:0] {IDLE, SETTLE, CONV, HOLD} state_t;

  localparam logic [CNT_W-1:0] PHASE_LAST  = CNT_W'(PHASE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             ch;        // 0 = RED, 1 = IR
  logic             start_q;
  logic             phase_end;
  logic             done_ok;

  assign adc.ADC_Start = start_q;
  assign phase_end     = (cnt == PHASE_LAST);
  // The ADC cannot have answered in the cycle its request is still being presented.
  assign done_ok       = (state == CONV) && adc.ADC_Done && !start_q;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      cnt             <= '0;
      ch              <= 1'b0;
      start_q         <= 1'b0;
      LED_RED         <= 1'b0;
      LED_IR          <= 1'b0;
      RED_ADC_Value   <= 8'h00;
      IR_ADC_Value    <= 8'h00;
      RED_Valid       <= 1'b0;
      IR_Valid        <= 1'b0;
      ADC_Timeout_Err <= 1'b0;
    end else begin
      start_q   <= 1'b0;
      RED_Valid <= 1'b0;
      IR_Valid  <= 1'b0;
      if (!enable) begin
        state   <= IDLE;
        cnt     <= '0;
        ch      <= 1'b0;
        LED_RED <= 1'b0;
        LED_IR  <= 1'b0;
      end else if (state == IDLE) begin
        state   <= SETTLE;
        cnt     <= '0;
        ch      <= 1'b0;
        LED_RED <= 1'b1;
        LED_IR  <= 1'b0;
      end else begin
        cnt <= cnt + 1'b1;
        if (done_ok) begin
          state <= HOLD;
          if (ch) begin
            IR_ADC_Value <= adc.ADC_Data;
            IR_Valid     <= 1'b1;
          end else begin
            RED_ADC_Value <= adc.ADC_Data;
            RED_Valid     <= 1'b1;
          end
        end else if (state == SETTLE && cnt == SETTLE_LAST) begin
          state   <= CONV;
          start_q <= 1'b1;
        end
        // Phase end overrides the above state choice; LEDs swap on this same edge.
        if (phase_end) begin
          if (state == CONV && !done_ok) ADC_Timeout_Err <= 1'b1;
          state   <= SETTLE;
          cnt     <= '0;
          ch      <= ~ch;
          LED_RED <= ch;
          LED_IR  <= ~ch;
          start_q <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_led_adc_sequencer.sv
// Directed bench for led_adc_sequencer with PHASE_CYCLES=20, SETTLE_CYCLES=4.
module tb_led_adc_sequencer;
  logic       CLK = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       LED_RED, LED_IR, RED_Valid, IR_Valid, ADC_Timeout_Err;
  logic [7:0] RED_ADC_Value, IR_ADC_Value;

  led_adc_sequencer_if adc ();

  led_adc_sequencer #(.PHASE_CYCLES(20), .SETTLE_CYCLES(4), .CNT_W(5)) dut (
    .CLK(CLK), .rst_n(rst_n), .enable(enable), .adc(adc.master),
    .LED_RED(LED_RED), .LED_IR(LED_IR),
    .RED_ADC_Value(RED_ADC_Value), .IR_ADC_Value(IR_ADC_Value),
    .RED_Valid(RED_Valid), .IR_Valid(IR_Valid), .ADC_Timeout_Err(ADC_Timeout_Err)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int red_cnt = 0;
  int ir_cnt = 0;
  int resp_cnt = 0;
  bit auto_en = 0;
  logic [7:0] red_data = 8'hA5;
  logic [7:0] ir_data  = 8'h3C;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock: sample after the edge, clear manual pulses, run the auto ADC responder.
  task automatic step();
    @(posedge CLK);
    #1;
    cyc++;
    adc.ADC_Done = 1'b0;
    if (RED_Valid) red_cnt++;
    if (IR_Valid)  ir_cnt++;
    chk("led_exclusive", 32'(LED_RED & LED_IR), 32'd0);
    chk("valid_exclusive", 32'(RED_Valid & IR_Valid), 32'd0);
    chk("valid_vs_start", 32'((RED_Valid | IR_Valid) & adc.ADC_Start), 32'd0);
    if (auto_en) begin
      if (adc.ADC_Start) resp_cnt = 3;
      else if (resp_cnt > 0) begin
        resp_cnt--;
        if (resp_cnt == 0) begin
          adc.ADC_Done = 1'b1;
          adc.ADC_Data = LED_RED ? red_data : ir_data;
        end
      end
    end
  endtask

  task automatic goto(input int n);
    while (cyc < n) step();
  endtask

  task automatic pulse(input logic [7:0] d);
    adc.ADC_Done = 1'b1;
    adc.ADC_Data = d;
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; adc.ADC_Done = 1'b0; adc.ADC_Data = 8'h00;
    #12;
    chk("rst_led_red", 32'(LED_RED), 0);
    chk("rst_led_ir", 32'(LED_IR), 0);
    chk("rst_start", 32'(adc.ADC_Start), 0);
    chk("rst_red_val", 32'(RED_ADC_Value), 0);
    chk("rst_err", 32'(ADC_Timeout_Err), 0);
    rst_n = 1'b1;
    cyc = 0; enable = 1'b1; auto_en = 1;

    // First RED phase
    goto(1);  chk("c1_led_red", 32'(LED_RED), 1);
    goto(4);  chk("c4_start", 32'(adc.ADC_Start), 0);
    goto(5);  chk("c5_start", 32'(adc.ADC_Start), 1);
    goto(6);  chk("c6_start", 32'(adc.ADC_Start), 0);
    goto(8);  chk("c8_red_valid", 32'(RED_Valid), 0);
    goto(9);  chk("c9_red_valid", 32'(RED_Valid), 1);
              chk("c9_red_val", 32'(RED_ADC_Value), 32'hA5);
    goto(10); chk("c10_red_valid", 32'(RED_Valid), 0);
    goto(20); chk("c20_led_red", 32'(LED_RED), 1);
    goto(21); chk("c21_led_red", 32'(LED_RED), 0);
              chk("c21_led_ir", 32'(LED_IR), 1);

    // IR phase: sample lands in IR register only
    goto(29); chk("c29_ir_valid", 32'(IR_Valid), 1);
              chk("c29_ir_val", 32'(IR_ADC_Value), 32'h3C);
              chk("c29_red_val", 32'(RED_ADC_Value), 32'hA5);
    goto(40); chk("c40_led_ir", 32'(LED_IR), 1);
              chk("win1_red_cnt", 32'(red_cnt), 1);
              chk("win1_ir_cnt", 32'(ir_cnt), 1);
    goto(41); chk("c41_led_red", 32'(LED_RED), 1);
    goto(80); chk("win2_red_cnt", 32'(red_cnt), 2);
              chk("win2_ir_cnt", 32'(ir_cnt), 2);

    // IR phase 101..120 with no ADC answer -> timeout
    goto(100); auto_en = 0; resp_cnt = 0;
    goto(120); chk("c120_err", 32'(ADC_Timeout_Err), 0);
    goto(121); chk("c121_err", 32'(ADC_Timeout_Err), 1);
               chk("c121_ir_cnt", 32'(ir_cnt), 2);
               chk("c121_ir_val", 32'(IR_ADC_Value), 32'h3C);
               chk("c121_led_red", 32'(LED_RED), 1);
    auto_en = 1; red_data = 8'h5A;
    goto(129); chk("c129_red_valid", 32'(RED_Valid), 1);
               chk("c129_red_val", 32'(RED_ADC_Value), 32'h5A);

    // IR phase 141..160: stray ADC_Done in SETTLE, start cycle and HOLD
    goto(140); auto_en = 0; resp_cnt = 0;
    goto(142); pulse(8'hFF);
    goto(143); chk("settle_ir_valid", 32'(IR_Valid), 0);
               chk("settle_ir_val", 32'(IR_ADC_Value), 32'h3C);
    goto(145); chk("c145_start", 32'(adc.ADC_Start), 1);
               pulse(8'hFF);
    goto(146); chk("startcyc_ir_valid", 32'(IR_Valid), 0);
    goto(148); pulse(8'h11);
    goto(149); chk("c149_ir_valid", 32'(IR_Valid), 1);
               chk("c149_ir_val", 32'(IR_ADC_Value), 32'h11);
    goto(152); pulse(8'hFF);
    goto(153); chk("hold_ir_valid", 32'(IR_Valid), 0);
               chk("hold_ir_val", 32'(IR_ADC_Value), 32'h11);
               chk("hold_red_val", 32'(RED_ADC_Value), 32'h5A);

    // RED phase 161..: disable one cycle after start
    goto(165); chk("c165_start", 32'(adc.ADC_Start), 1);
    goto(166); enable = 1'b0;
    goto(167); chk("dis_led_red", 32'(LED_RED), 0);
               chk("dis_led_ir", 32'(LED_IR), 0);
               chk("dis_start", 32'(adc.ADC_Start), 0);
    goto(168); pulse(8'h99);
    goto(169); chk("dis_red_valid", 32'(RED_Valid), 0);
               chk("dis_red_val", 32'(RED_ADC_Value), 32'h5A);
    goto(170); enable = 1'b1;
    goto(171); chk("reen_led_red", 32'(LED_RED), 1);
    goto(174); chk("reen_c174_start", 32'(adc.ADC_Start), 0);
    goto(175); chk("reen_c175_start", 32'(adc.ADC_Start), 1);
    goto(178); pulse(8'h66);
    goto(179); chk("reen_red_valid", 32'(RED_Valid), 1);
               chk("reen_red_val", 32'(RED_ADC_Value), 32'h66);
               chk("reen_err_sticky", 32'(ADC_Timeout_Err), 1);

    // Asynchronous reset mid-HOLD
    goto(180);
    rst_n = 1'b0;
    #1;
    chk("arst_led_red", 32'(LED_RED), 0);
    chk("arst_red_val", 32'(RED_ADC_Value), 0);
    chk("arst_err", 32'(ADC_Timeout_Err), 0);
    rst_n = 1'b1;
    cyc = 0;

    // ADC_Done exactly at phase end in CONV: accepted, no error
    goto(1);  chk("rel_led_red", 32'(LED_RED), 1);
    goto(5);  chk("rel_c5_start", 32'(adc.ADC_Start), 1);
    goto(20); pulse(8'h42);
    goto(21); chk("edge_red_valid", 32'(RED_Valid), 1);
              chk("edge_red_val", 32'(RED_ADC_Value), 32'h42);
              chk("edge_err", 32'(ADC_Timeout_Err), 0);
              chk("edge_led_ir", 32'(LED_IR), 1);
    goto(22); chk("edge_red_valid_off", 32'(RED_Valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
